// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : Iterative multiply/divide unit with architectural HI/LO
//             registers. It serves MULT, MULTU, DIV, DIVU, MTHI and MTLO, and
//             produces one result bit per cycle.
//  Ports    : Clock        - rising-edge clock
//             Reset        - synchronous active-high reset
//             Start        - request strobe, sampled only while Busy=0
//             Op[2:0]      - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                            100 MTHI, 101 MTLO, 11x no-op
//             A, B         - rs / rt operands
//             Busy         - arithmetic operation in progress
//             Done         - one-cycle pulse when MULT/DIV writes HI/LO
//             Hi, Lo       - architectural HI / LO registers
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide: the low half holds the dividend, which is shifted out while the
  // quotient bits are shifted in.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     rem_q, rem_d;      // divide partial remainder
  logic [WIDTH-1:0]     opb_q, opb_d;      // multiplicand / divisor magnitude
  logic [WIDTH-1:0]     a_orig_q, a_orig_d;
  logic                 is_div_q, is_div_d;
  logic                 b_zero_q, b_zero_d;
  logic                 neg_q, neg_d;      // negate product / quotient
  logic                 rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  // Operand magnitudes. Negating the most-negative value returns the same
  // bit pattern, and that pattern is the correct unsigned magnitude.
  logic                 signed_op;
  logic [WIDTH-1:0]     a_mag, b_mag;
  assign signed_op = ~Op[0];
  assign a_mag = (signed_op && A[WIDTH-1]) ? -A : A;
  assign b_mag = (signed_op && B[WIDTH-1]) ? -B : B;

  // Shift-add step. The extra sum bit keeps the carry.
  logic [WIDTH:0]       mul_sum;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                   (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});

  // Restoring-division step on a WIDTH+1-bit shifted remainder.
  logic [WIDTH:0]       div_shift, div_diff;
  logic                 div_ge;
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign div_ge    = (div_shift >= {1'b0, opb_q});

  // Sign correction. Most-negative / -1 needs no special case: the
  // magnitude quotient 2^(WIDTH-1) is not negated because the signs match,
  // and the remainder is 0.
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;
  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = rem_neg_q ? -rem_q : rem_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    opb_d     = opb_q;
    a_orig_d  = a_orig_q;
    is_div_d  = is_div_q;
    b_zero_d  = b_zero_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          case (Op[2:1])
            2'b00, 2'b01: begin
              state_d   = S_CALC;
              cnt_d     = '0;
              acc_d     = {{WIDTH{1'b0}}, a_mag};
              rem_d     = '0;
              opb_d     = b_mag;
              a_orig_d  = A;
              is_div_d  = Op[1];
              b_zero_d  = (B == '0);
              neg_d     = signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
              rem_neg_d = signed_op & A[WIDTH-1];
            end
            2'b10: begin
              if (Op[0]) lo_d = A;
              else       hi_d = A;
            end
            default: ;
          endcase
        end
      end

      S_CALC: begin
        if (is_div_q) begin
          rem_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
        else                            cnt_d   = cnt_q + 1'b1;
      end

      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (b_zero_q) begin
          // Division by zero returns all ones and the untouched dividend.
          hi_d = a_orig_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      opb_q     <= '0;
      a_orig_q  <= '0;
      is_div_q  <= 1'b0;
      b_zero_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      opb_q     <= opb_d;
      a_orig_q  <= a_orig_d;
      is_div_q  <= is_div_d;
      b_zero_q  <= b_zero_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign Busy = (state_q != S_IDLE);
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS32 datapath. It sits beside the single-cycle ALU in the execute stage and serves MULT, MULTU, DIV, DIVU, MTHI and MTLO. It computes iteratively, one result bit per cycle. Busy/Done handshake lets the pipeline stall MFHI/MFLO until results are valid.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; must be ≥ 4 and even
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

- Clock  in  1  single clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high; clears all state on the next rising edge
- Start  in  1  request strobe; sampled only when Busy=0
- Op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
- A  in  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO source)
- B  in  WIDTH  rt operand (multiplier / divisor)
- Busy  out  1  high while an arithmetic operation is in progress
- Done  out  1  one-cycle pulse when HI/LO have just been written by MULT/DIV
- Hi  out  WIDTH  HI register
- Lo  out  WIDTH  LO register

## Operation
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - Start=1 with Op MULT/MULTU/DIV/DIVU: latch the operands, convert them to magnitudes, record the result signs, and clear the counter. Go to CALC.
    - Signed ops use magnitudes.
    - Unsigned ops latch the operands unchanged.
  - Start=1 with MTHI: Hi←A on that edge. Stay in IDLE. Done stays low.
  - Start=1 with MTLO: Lo←A on that edge. Stay in IDLE. Done stays low.
  - Start=1 with a no-op Op: ignored.
- CALC, multiply: shift-add, radix 2, one multiplier bit per cycle, into a 2·WIDTH internal accumulator.
- CALC, divide: restoring division, one quotient bit per cycle, with a WIDTH+1-bit partial remainder.
- CALC runs for exactly WIDTH cycles, then goes to FIX.
- FIX: apply the sign correction, write Hi/Lo, pulse Done, return to IDLE.
- Sign rules:
  - Signed product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
- Results:
  - Multiply: Hi = upper WIDTH bits, Lo = lower WIDTH bits.
  - Divide: Lo = quotient, Hi = remainder.
- Divide by zero (B=0), signed or unsigned: Lo = all ones, Hi = A as originally supplied. No trap.
- Signed overflow (most-negative / −1): Lo = most-negative, Hi = 0.
- Hi/Lo hold their previous values throughout CALC. They are readable until the FIX write.
- Start while Busy=1 is ignored, including MTHI/MTLO. Issue logic must not rely on it.

## Timing
- Reset values: Hi=0, Lo=0, Busy=0, Done=0, state=IDLE, counter=0.
- Reset asserted mid-operation aborts the operation. Hi/Lo are cleared, not left with partial results.
- Start accepted at edge e0.
  - Busy=1 from just after e0 until edge e(WIDTH+1).
  - Hi/Lo are written and Done=1 after edge e(WIDTH+1), when Busy returns to 0.
  - Latency: WIDTH+1 cycles; for WIDTH=32, 33 cycles.
- Done lasts exactly one cycle. It is never asserted by MTHI/MTLO.
- Back-to-back: Start may be asserted in the same cycle Done=1, because Busy=0 then. It is accepted at the next edge, giving an issue interval of WIDTH+2 cycles.
- MTHI/MTLO take effect in 1 cycle; the value is visible after the accepting edge.
- Reset has priority over Start on the same edge.

## Test plan
- **MULT:** WIDTH=32, Op=MULT, A=0xFFFFFFFE (−2), B=3. Required: Done exactly 33 cycles after the Start edge; Hi=0xFFFFFFFF, Lo=0xFFFFFFFA.
- **MULTU:** A=0xFFFFFFFF, B=0xFFFFFFFF. Required: Hi=0xFFFFFFFE, Lo=0x00000001. During CALC, Hi/Lo keep their prior values.
- **DIV:** A=0xFFFFFFF9 (−7), B=2. Required: Lo=0xFFFFFFFD (−3), Hi=0xFFFFFFFF (−1).
- **DIV overflow:** A=0x80000000, B=0xFFFFFFFF. Required: Lo=0x80000000, Hi=0.
- **DIVU by zero:** A=7, B=0. Required: Lo=0xFFFFFFFF, Hi=0x00000007.
- **Ignored Start, MTHI, reset abort:**
  - Start MULT with A=5, B=6.
  - Assert Start with MTHI, A=0x1234, at cycle 10. Required: ignored, Hi unchanged.
  - At completion, required: Hi=0, Lo=30.
  - Then issue MTHI with A=0x1234. Required: Hi=0x1234 after one edge, no Done.
  - Start DIVU and pulse Reset at cycle 5. Required: Busy=0, Done=0, Hi=Lo=0 on the next edge, and no later Done.
